// File: rtl/spi_master_cfg_if.sv
// Command/response bus of the SPI master: valid/ready transmit request,
// per-transfer mode and chip-select selection, received word and status.
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2
);
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [SEL_W-1:0]  cs_sel;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport slave (
    input  tx_valid, tx_data, cs_sel, cpol, cpha,
    output tx_ready, rx_data, rx_valid, busy
  );

  modport master (
    output tx_valid, tx_data, cs_sel, cpol, cpha,
    input  tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with runtime CPOL/CPHA, fixed bit order, NUM_CS
// active-low chip selects and CLK_DIV-cycle SCLK half-periods.
module spi_master_cfg #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int NUM_CS    = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_cfg_if.slave   cmd,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam int BIT_W  = HALF_W - 1;
  localparam int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [HALF_W-1:0]   half;
  logic [DATA_W-1:0]   tx_ord, tx_sh, rx_sh, rx_next, rx_q;
  logic [NUM_CS-1:0]   cs_dec;
  logic [BIT_W-1:0]    period;
  logic                cpol_q, cpha_q;
  logic                cnt_end, shift_end, accept;
  logic                leading, first_period, last_period, sample, advance;

  assign cnt_end      = (cnt == CNT_LAST);
  assign shift_end    = cnt_end && (half == HALF_LAST);
  assign accept       = (state == IDLE) && cmd.tx_valid;
  assign period       = half[HALF_W-1:1];
  assign leading      = ~half[0];
  assign first_period = (period == '0);
  assign last_period  = (period == BIT_LAST);
  // Leading edge samples for CPHA=0, trailing edge for CPHA=1; mosi moves on the other edge.
  assign sample       = leading ^ cpha_q;
  assign advance      = leading ? (cpha_q && !first_period) : (!cpha_q && !last_period);

  assign cmd.tx_ready = (state == IDLE);
  assign cmd.busy     = (state != IDLE);
  assign cmd.rx_valid = (state == DONE);
  assign cmd.rx_data  = rx_q;

  // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    tx_ord  = cmd.tx_data;
    rx_next = {miso, rx_sh[DATA_W-1:1]};
    cs_dec  = '1;
    if (MSB_FIRST) begin
      for (int i = 0; i < DATA_W; i++) tx_ord[i] = cmd.tx_data[DATA_W-1-i];
      rx_next = {rx_sh[DATA_W-2:0], miso};
    end
    for (int i = 0; i < NUM_CS; i++) begin
      if (cmd.cs_sel == SEL_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd.tx_valid) state_nxt = LEAD;
      LEAD:    if (cnt_end)      state_nxt = SHIFT;
      SHIFT:   if (shift_end)    state_nxt = TRAIL;
      TRAIL:   if (cnt_end)      state_nxt = DONE;
      DONE:                      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      half <= '0;
    end else begin
      if (state == LEAD || state == SHIFT || state == TRAIL) cnt <= cnt_end ? '0 : cnt + 1'b1;
      else                                                   cnt <= '0;
      if (state != SHIFT)  half <= '0;
      else if (cnt_end)    half <= shift_end ? '0 : half + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      cs_n   <= '1;
      rx_q   <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk <= cmd.cpol;
          if (accept) begin
            tx_sh  <= tx_ord;
            mosi   <= tx_ord[0];
            cs_n   <= cs_dec;
            cpol_q <= cmd.cpol;
            cpha_q <= cmd.cpha;
          end
        end
        SHIFT: begin
          if (cnt_end) begin
            sclk <= ~sclk;
            if (sample) rx_sh <= rx_next;
            if (advance) begin
              tx_sh <= tx_sh >> 1;
              mosi  <= tx_sh[1];
            end
          end
        end
        TRAIL: begin
          if (cnt_end) begin
            cs_n <= '1;
            rx_q <= rx_sh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
